circulant_transpose_ctrl: RTL and testbench

Sequencer for the circulant BRAM transpose datapath (circulant_barrel_shifter_v2). It accepts a stream of MATRIX_DIM row words and writes them into the circulant memory. It then issues MATRIX_DIM diagonal reads, collects the shifted results in a small credit-managed output FIFO, and streams the transposed rows out under valid/ready backpressure. It sits between the upstream row producer and the downstream consumer; the shifter instance is external and driven by this block's mem_* ports.

---
 rtl/circ_xpose_pkg.sv | 16 +
 rtl/circ_xpose_out_fifo.sv | 63 ++++++
 rtl/circulant_transpose_ctrl.sv | 173 +++++++++++++++++
 tb/tb_circulant_transpose_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circ_xpose_pkg.sv
// Shared definitions for the circulant transpose sequencer.
//   state_e   : sequencer phases (fill rows, drain diagonals, flush pipe)
//   cnt_width : width of a counter that must hold 0..depth inclusive
package circ_xpose_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/circ_xpose_out_fifo.sv
// Output FIFO for transposed rows, with occupancy count.
//   clk, rst      : clock, asynchronous active-high reset (FIFO emptied)
//   push_i/data_i : write one row
//   pop_i         : remove head (ignored when empty)
//   data_o        : head row, read from registered storage
//   count_o       : number of stored rows
//   empty_o       : no rows stored
// Writing into a full FIFO is a sequencing error and is flagged by an assertion.
module circ_xpose_out_fifo
  import circ_xpose_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      unique case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/circulant_transpose_ctrl.sv
// Sequencer for the circulant BRAM transpose datapath. Accepts MATRIX_DIM
// row words, writes them into the external circulant shifter, then issues
// MATRIX_DIM diagonal reads whose results are buffered in a credit-managed
// FIFO and streamed out as transposed rows.
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_shift_en        : barrel-shift enable, latched on the first row of a matrix
//   in_valid/in_ready/in_data    : upstream row stream
//   out_valid/out_ready/out_data : transposed row stream (FIFO head)
//   mem_wen, mem_w_base_mem, mem_w_base_addr, mem_wdata : shifter write port
//   mem_ren, mem_r_base_mem, mem_r_base_addr            : shifter read port
//   mem_shift_en, mem_rdata                              : shift control, read data
//   busy                : high while draining or flushing
// Optional: define CIRC_XPOSE_PERF_EN to add perf_stall_cnt / perf_matrix_cnt.
module circulant_transpose_ctrl
  import circ_xpose_pkg::*;
#(
  parameter int unsigned MATRIX_DIM = 4,
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned ROW_WIDTH  = MATRIX_DIM * MEM_WIDTH,
  parameter int unsigned ADDR_LEN   = $clog2(MATRIX_DIM),
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = READ_LAT + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_shift_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROW_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_WIDTH-1:0] out_data,
  output logic                 mem_wen,
  output logic [ADDR_LEN-1:0]  mem_w_base_mem,
  output logic [ADDR_LEN-1:0]  mem_w_base_addr,
  output logic [ROW_WIDTH-1:0] mem_wdata,
  output logic                 mem_ren,
  output logic [ADDR_LEN-1:0]  mem_r_base_mem,
  output logic [ADDR_LEN-1:0]  mem_r_base_addr,
  output logic                 mem_shift_en,
  input  logic [ROW_WIDTH-1:0] mem_rdata,
  output logic                 busy
`ifdef CIRC_XPOSE_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_matrix_cnt
`endif
);

  localparam int unsigned         CNT_W      = cnt_width(FIFO_DEPTH);
  localparam logic [ADDR_LEN-1:0] LAST_IDX   = ADDR_LEN'(MATRIX_DIM - 1);
  localparam logic [CNT_W:0]      CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_LEN-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [READ_LAT-1:0] ret_vld_q, ret_vld_d;
  logic                shift_en_q, shift_en_d;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty, fifo_pop, ret_push, credit_ok;

  // Reads already in flight plus rows already buffered must leave room,
  // so every returning read is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDIT_LIM;
  assign ret_push  = ret_vld_q[READ_LAT-1];
  assign fifo_pop  = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (mem_wen && wr_cnt_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN: if (mem_ren && rd_cnt_q == LAST_IDX) state_d = ST_FLUSH;
      ST_FLUSH: if (outstanding_q == '0 && fifo_empty) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  // Output logic; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    mem_wen  = 1'b0;
    mem_ren  = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        in_ready = !rst;
        mem_wen  = in_valid && !rst;
      end
      ST_DRAIN: begin
        mem_ren = credit_ok;
        busy    = 1'b1;
      end
      ST_FLUSH: busy = 1'b1;
      default: ;
    endcase
  end

  // Counters, shift latch and return-valid pipe
  always_comb begin
    wr_cnt_d      = mem_wen ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_cnt_d      = mem_ren ? rd_cnt_q + 1'b1 : rd_cnt_q;
    shift_en_d    = (mem_wen && wr_cnt_q == '0) ? cfg_shift_en : shift_en_q;
    outstanding_d = outstanding_q + CNT_W'(mem_ren) - CNT_W'(ret_push);
    ret_vld_d     = READ_LAT'({ret_vld_q, mem_ren});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      shift_en_q    <= 1'b0;
      outstanding_q <= '0;
      ret_vld_q     <= '0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      shift_en_q    <= shift_en_d;
      outstanding_q <= outstanding_d;
      ret_vld_q     <= ret_vld_d;
    end
  end

  assign mem_w_base_mem  = '0;
  assign mem_w_base_addr = wr_cnt_q;
  assign mem_wdata       = in_data;
  assign mem_r_base_mem  = '0;
  assign mem_r_base_addr = rd_cnt_q;
  assign mem_shift_en    = shift_en_q;
  assign out_valid       = !fifo_empty;

  circ_xpose_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_WIDTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ret_push),
    .data_i  (mem_rdata),
    .pop_i   (fifo_pop),
    .data_o  (out_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

`ifdef CIRC_XPOSE_PERF_EN
  logic [31:0] perf_stall_q, perf_matrix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_matrix_q <= '0;
    end else begin
      if (out_valid && !out_ready && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (state_q == ST_FLUSH && state_d == ST_FILL && perf_matrix_q != '1)
        perf_matrix_q <= perf_matrix_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_matrix_cnt = perf_matrix_q;
`endif

endmodule

// File: tb/tb_circulant_transpose_ctrl.sv
module tb_circulant_transpose_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = N * W;
  localparam int AL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_shift_en;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          mem_wen;
  logic [AL-1:0] mem_w_base_mem;
  logic [AL-1:0] mem_w_base_addr;
  logic [RW-1:0] mem_wdata;
  logic          mem_ren;
  logic [AL-1:0] mem_r_base_mem;
  logic [AL-1:0] mem_r_base_addr;
  logic          mem_shift_en;
  logic [RW-1:0] mem_rdata;
  logic          busy;
`ifdef CIRC_XPOSE_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_matrix_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [RW-1:0] sb [$];
  int            wen_addr_q [$];
  int            wen_cyc_q [$];
  int            ren_addr_q [$];
  int            ren_cyc_q [$];

  circulant_transpose_ctrl #(
    .MATRIX_DIM (N),
    .MEM_WIDTH  (W),
    .READ_LAT   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_shift_en    (cfg_shift_en),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .mem_wen         (mem_wen),
    .mem_w_base_mem  (mem_w_base_mem),
    .mem_w_base_addr (mem_w_base_addr),
    .mem_wdata       (mem_wdata),
    .mem_ren         (mem_ren),
    .mem_r_base_mem  (mem_r_base_mem),
    .mem_r_base_addr (mem_r_base_addr),
    .mem_shift_en    (mem_shift_en),
    .mem_rdata       (mem_rdata),
    .busy            (busy)
`ifdef CIRC_XPOSE_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_matrix_cnt (perf_matrix_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural circulant memory + barrel shifter, two-cycle read latency.
  // Element j of row a lives in bank (j+a)%N at address a.
  logic [W-1:0]  bank [N][N];
  logic [RW-1:0] pipe0, pipe1;
  assign mem_rdata = pipe1;

  always @(posedge clk) begin : shifter_model
    logic [RW-1:0] raw, rot;
    int d;
    if (mem_wen)
      for (int j = 0; j < N; j++)
        bank[(j + int'(mem_w_base_addr)) % N][mem_w_base_addr] <= mem_wdata[j*W +: W];
    if (mem_ren) begin
      d = int'(mem_r_base_addr);
      for (int b = 0; b < N; b++) raw[b*W +: W] = bank[b][(b - d + N) % N];
      if (mem_shift_en)
        for (int k = 0; k < N; k++) rot[k*W +: W] = raw[((k + d) % N)*W +: W];
      else
        rot = raw;
      pipe0 <= rot;
    end else begin
      pipe0 <= 32'hDEAD_BEEF;
    end
    pipe1 <= pipe0;
  end

  // Expected transposed row c: shifted gives lane k = M[k][c];
  // unshifted leaves lane b = M[(b-c)%N][c].
  function automatic logic [RW-1:0] expect_row(input logic [RW-1:0] m [N], input int c,
                                               input logic sh);
    logic [RW-1:0] r;
    logic [RW-1:0] row;
    int src;
    r = '0;
    for (int b = 0; b < N; b++) begin
      src = sh ? b : (b - c + N) % N;
      row = m[src];
      r[b*W +: W] = row[c*W +: W];
    end
    return r;
  endfunction

  // Monitor: scoreboard pop on output handshakes plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL out_valid_in_reset: got %0b required 0", out_valid);
      end
    end else begin
      checks++;
      if (mem_wen && mem_ren) begin
        errors++;
        $display("FAIL wen_ren_exclusive: wen=%0b ren=%0b required not both", mem_wen, mem_ren);
      end
      if (busy && in_ready) begin
        errors++;
        $display("FAIL in_ready_while_busy: in_ready=%0b required 0", in_ready);
      end
      if (mem_wen) begin
        wen_addr_q.push_back(int'(mem_w_base_addr));
        wen_cyc_q.push_back(cyc);
        if (mem_w_base_mem !== '0) begin
          errors++;
          $display("FAIL w_base_mem: got %0d required 0", mem_w_base_mem);
        end
      end
      if (mem_ren) begin
        ren_addr_q.push_back(int'(mem_r_base_addr));
        ren_cyc_q.push_back(cyc);
        if (mem_r_base_mem !== '0) begin
          errors++;
          $display("FAIL r_base_mem: got %0d required 0", mem_r_base_mem);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row: got %08h required no output", out_data);
        end else begin
          logic [RW-1:0] exp_row;
          exp_row = sb.pop_front();
          if (out_data !== exp_row) begin
            errors++;
            $display("FAIL out_data: got %08h required %08h", out_data, exp_row);
          end
        end
      end
    end
  end

  task automatic clear_logs();
    wen_addr_q.delete(); wen_cyc_q.delete();
    ren_addr_q.delete(); ren_cyc_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called and returns at posedge+1.
  task automatic drive_row(input logic [RW-1:0] row, input logic sh);
    int unsigned n;
    n = 0;
    in_valid = 1'b1; in_data = row; cfg_shift_en = sh;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Later beats carry the opposite cfg_shift_en: only the first beat may latch it.
  task automatic send_matrix(input logic [RW-1:0] m [N], input logic sh, input bit gap);
    for (int c = 0; c < N; c++) sb.push_back(expect_row(m, c, sh));
    for (int r = 0; r < N; r++) begin
      drive_row(m[r], (r == 0) ? sh : !sh);
      if (gap) begin @(posedge clk); #1; end
    end
    checks++;
    if (mem_shift_en !== sh) begin
      errors++;
      $display("FAIL mem_shift_en: got %0b required %0b", mem_shift_en, sh);
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !busy && in_ready) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0 || busy || !in_ready) begin
      errors++;
      $display("FAIL %s_idle: pending=%0d busy=%0b in_ready=%0b required 0 0 1",
               tag, sb.size(), busy, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_addr_seq(input string tag, input int q [$]);
    checks++;
    if (q.size() != N) begin
      errors++;
      $display("FAIL %s_count: got %0d required %0d", tag, q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (q[i] != i) begin
          errors++;
          $display("FAIL %s_addr%0d: got %0d required %0d", tag, i, q[i], i);
        end
      end
    end
  endtask

  logic [RW-1:0] m1 [N];
  logic [RW-1:0] m2 [N];

  task automatic test_reset();
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_wen !== 1'b0 || mem_ren !== 1'b0 || busy !== 1'b0 ||
        mem_shift_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b wen=%0b ren=%0b busy=%0b shift=%0b required all 0",
               in_ready, mem_wen, mem_ren, busy, mem_shift_en);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_after_reset: got %0b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    clear_logs();
    send_matrix(m1, 1'b1, 1'b0);
    wait_idle("basic");
    check_addr_seq("basic_wen", wen_addr_q);
    check_addr_seq("basic_ren", ren_addr_q);
    checks++;
    if (wen_cyc_q.size() == N && wen_cyc_q[N-1] != wen_cyc_q[0] + N - 1) begin
      errors++;
      $display("FAIL basic_wen_span: got %0d required %0d", wen_cyc_q[N-1] - wen_cyc_q[0], N - 1);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    clear_logs();
    send_matrix(m1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (ren_addr_q.size() != 3) begin
      errors++;
      $display("FAIL bp_reads_held: got %0d required 3", ren_addr_q.size());
    end
    checks++;
    if (out_valid !== 1'b1 || mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL bp_state: out_valid=%0b ren=%0b required 1 0", out_valid, mem_ren);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("bp");
    check_addr_seq("bp_ren", ren_addr_q);
  endtask

  task automatic test_in_valid_gaps();
    out_ready = 1'b1;
    clear_logs();
    send_matrix(m2, 1'b1, 1'b1);
    wait_idle("gaps");
    check_addr_seq("gaps_wen", wen_addr_q);
    checks++;
    if (wen_cyc_q.size() == N && wen_cyc_q[N-1] != wen_cyc_q[0] + 2 * (N - 1)) begin
      errors++;
      $display("FAIL gaps_wen_span: got %0d required %0d", wen_cyc_q[N-1] - wen_cyc_q[0], 2 * (N - 1));
    end
    checks++;
    if (wen_cyc_q.size() == N && ren_cyc_q.size() > 0 && ren_cyc_q[0] != wen_cyc_q[N-1] + 1) begin
      errors++;
      $display("FAIL gaps_drain_entry: got cycle %0d required %0d", ren_cyc_q[0], wen_cyc_q[N-1] + 1);
    end
  endtask

  task automatic test_reset_mid_drain();
    int unsigned n;
    n = 0;
    out_ready = 1'b0;
    clear_logs();
    send_matrix(m1, 1'b1, 1'b0);
    @(negedge clk);
    while (ren_addr_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (ren_addr_q.size() != 2) begin
      errors++;
      $display("FAIL rst_reads_before: got %0d required 2", ren_addr_q.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mem_ren !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drain: out_valid=%0b busy=%0b ren=%0b in_ready=%0b required 0 0 0 0",
               out_valid, busy, mem_ren, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    send_matrix(m2, 1'b1, 1'b0);
    wait_idle("rst_next");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    clear_logs();
    send_matrix(m1, 1'b1, 1'b0);
    send_matrix(m2, 1'b0, 1'b0);
    wait_idle("b2b");
    checks++;
    if (ren_addr_q.size() != 2 * N) begin
      errors++;
      $display("FAIL b2b_reads: got %0d required %0d", ren_addr_q.size(), 2 * N);
    end
  endtask

`ifdef CIRC_XPOSE_PERF_EN
  task automatic test_perf();
    int unsigned n;
    n = 0;
    apply_reset();
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_matrix_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: stall=%0d matrix=%0d required 0 0", perf_stall_cnt, perf_matrix_cnt);
    end
    out_ready = 1'b0;
    send_matrix(m1, 1'b1, 1'b0);
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("perf");
    checks++;
    if (perf_stall_cnt !== 32'd10) begin
      errors++;
      $display("FAIL perf_stall: got %0d required 10", perf_stall_cnt);
    end
    checks++;
    if (perf_matrix_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_matrix: got %0d required 1", perf_matrix_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_shift_en = 1'b0; out_ready = 1'b1;
    m1[0] = 32'h03020100; m1[1] = 32'h07060504; m1[2] = 32'h0B0A0908; m1[3] = 32'h0F0E0D0C;
    for (int i = 0; i < N; i++) m2[i] = $urandom;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_in_valid_gaps();
    test_reset_mid_drain();
    test_back_to_back();
`ifdef CIRC_XPOSE_PERF_EN
    test_perf();
`endif
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
